// File: rtl/ray_pkg.sv
// Shared types for the primary-ray stream generator: FSM states and the
// packed ray-direction record carried through the output register.
package ray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } raygen_state_t;

    localparam int RAY_DIR_W = 32;

    typedef struct packed {
        logic signed [RAY_DIR_W-1:0] x;
        logic signed [RAY_DIR_W-1:0] y;
        logic signed [RAY_DIR_W-1:0] z;
    } ray_dir_t;

endpackage

// File: rtl/ray_stream_generator_pixel_scanner.sv
// Raster x/y scan counters: clear to (0,0), advance one pixel per request,
// wrap x at width-1 into the next row, flag the final pixel of the frame.
module pixel_scanner
    import ray_pkg::*;
#(
    parameter int DIM_W = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             last
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             row_end;

    assign row_end = (x_q == width - DIM_W'(1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (row_end) begin
                x_d = '0;
                // After the final pixel the scan folds back to the origin.
                y_d = (y_q == height - DIM_W'(1)) ? '0 : y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = row_end && (y_q == height - DIM_W'(1));

endmodule

// File: rtl/ray_stream_generator.sv
// Streams one primary-ray direction per pixel in raster order over valid/ready.
// Optional build macro RAYGEN_SUBPIXEL_EN aims rays at pixel centres (1 fractional bit).
module ray_stream_generator
    import ray_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int FOCAL_W = 32,
    parameter int DIM_W   = 13,
    parameter int DIR_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [COORD_W-1:0] camera_dir_x,
    input  logic signed [COORD_W-1:0] camera_dir_y,
    input  logic        [FOCAL_W-1:0] focal,
    input  logic        [DIM_W-1:0]   image_width,
    input  logic        [DIM_W-1:0]   image_height,
    output logic                      ray_valid,
    input  logic                      ray_ready,
    output logic signed [DIR_W-1:0]   ray_dir_x,
    output logic signed [DIR_W-1:0]   ray_dir_y,
    output logic signed [DIR_W-1:0]   ray_dir_z,
    output logic        [DIM_W-1:0]   ray_px,
    output logic        [DIM_W-1:0]   ray_py,
    output logic                      ray_last,
    output logic                      busy,
    output logic                      done
);

    localparam int PROD_W = FOCAL_W + COORD_W + 1;
    localparam logic signed [DIR_W-1:0] ONE_S = DIR_W'(1);

    // Direction for pixel (x,y) from the latched frame configuration.
    function automatic ray_dir_t calc_ray(
        input logic signed [DIR_W-1:0]   off_x,
        input logic signed [DIR_W-1:0]   off_y,
        input logic        [FOCAL_W-1:0] f,
        input logic        [DIM_W-1:0]   w,
        input logic        [DIM_W-1:0]   h,
        input logic        [DIM_W-1:0]   px,
        input logic        [DIM_W-1:0]   py
    );
        logic signed [DIR_W-1:0] bx;
        logic signed [DIR_W-1:0] by;
        logic signed [DIR_W-1:0] fz;
        ray_dir_t                r;
        bx = off_x + signed'(DIR_W'(px)) - signed'(DIR_W'(w >> 1));
        by = off_y - signed'(DIR_W'(py)) + signed'(DIR_W'(h >> 1));
        fz = signed'(DIR_W'(f));
`ifdef RAYGEN_SUBPIXEL_EN
        r.x = RAY_DIR_W'(bx + bx + ONE_S);
        r.y = RAY_DIR_W'(by + by - ONE_S);
        r.z = RAY_DIR_W'(fz + fz);
`else
        r.x = RAY_DIR_W'(bx);
        r.y = RAY_DIR_W'(by - ONE_S);
        r.z = RAY_DIR_W'(fz);
`endif
        return r;
    endfunction

    raygen_state_t           state_q, state_d;
    logic                    valid_q, valid_d;
    ray_dir_t                ray_q, ray_d;
    logic [DIM_W-1:0]        px_q, px_d;
    logic [DIM_W-1:0]        py_q, py_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [DIM_W-1:0]        width_q, width_d;
    logic [DIM_W-1:0]        height_q, height_d;
    logic [FOCAL_W-1:0]      focal_q, focal_d;
    logic signed [DIR_W-1:0] off_x_q, off_x_d;
    logic signed [DIR_W-1:0] off_y_q, off_y_d;

    logic signed [PROD_W-1:0] prod_x;
    logic signed [PROD_W-1:0] prod_y;
    logic                     scan_clear;
    logic                     scan_adv;
    logic [DIM_W-1:0]         scan_x;
    logic [DIM_W-1:0]         scan_y;
    logic                     scan_last;
    logic                     xfer;

    // Focal is unsigned, so a zero sign bit keeps the product signed-correct.
    assign prod_x = PROD_W'($signed({1'b0, focal})) * PROD_W'(camera_dir_x);
    assign prod_y = PROD_W'($signed({1'b0, focal})) * PROD_W'(camera_dir_y);
    assign xfer   = valid_q && ray_ready;

    pixel_scanner #(
        .DIM_W (DIM_W)
    ) u_scanner (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (scan_clear),
        .advance (scan_adv),
        .width   (width_q),
        .height  (height_q),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ray_d      = ray_q;
        px_d       = px_q;
        py_d       = py_q;
        last_d     = last_q;
        done_d     = 1'b0;
        width_d    = width_q;
        height_d   = height_q;
        focal_d    = focal_q;
        off_x_d    = off_x_q;
        off_y_d    = off_y_q;
        scan_clear = 1'b0;
        scan_adv   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                width_d    = image_width;
                height_d   = image_height;
                focal_d    = focal;
                off_x_d    = DIR_W'(prod_x);
                off_y_d    = DIR_W'(prod_y);
                scan_clear = 1'b1;
                if (abort || image_width == '0 || image_height == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort || (xfer && last_q)) begin
                    // Abort wins over a coincident transfer and drops an unaccepted ray.
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                    done_d     = 1'b1;
                    scan_clear = 1'b1;
                end else if (!valid_q || ray_ready) begin
                    valid_d  = 1'b1;
                    ray_d    = calc_ray(off_x_q, off_y_q, focal_q, width_q, height_q,
                                        scan_x, scan_y);
                    px_d     = scan_x;
                    py_d     = scan_y;
                    last_d   = scan_last;
                    scan_adv = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            ray_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            focal_q  <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ray_q    <= ray_d;
            px_q     <= px_d;
            py_q     <= py_d;
            last_q   <= last_d;
            done_q   <= done_d;
            width_q  <= width_d;
            height_q <= height_d;
            focal_q  <= focal_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
        end
    end

    assign ray_valid = valid_q;
    assign ray_dir_x = DIR_W'(ray_q.x);
    assign ray_dir_y = DIR_W'(ray_q.y);
    assign ray_dir_z = DIR_W'(ray_q.z);
    assign ray_px    = px_q;
    assign ray_py    = py_q;
    assign ray_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
